spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 35 +++
 rtl/spi_peripheral.sv | 147 ++++++++++++++
 tb/tb_spi_peripheral.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared word width, state encoding and underrun fill byte for the SPI peripheral.
// Rev 1.0
`default_nettype none

package spi_pkg;

  localparam int WORD_BITS = 8;
  localparam int CNT_BITS  = $clog2(WORD_BITS);

  localparam logic [WORD_BITS-1:0] UNDERRUN_FILL = 8'h00;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_SELECTED = 1'b1
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with rise/fall pulses derived from a one-cycle-delayed copy.
// Rev 1.0
`default_nettype none

module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Preset to the line's idle level so reset never manufactures an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign rise = stages[SYNC_STAGES-1] & ~prev;
  assign fall = ~stages[SYNC_STAGES-1] & prev;

endmodule

`default_nettype wire

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 peripheral, 8-bit MSB-first, with a single-entry transmit holding register.
// Rev 1.0
`default_nettype none

module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sclk,
  input  logic                 i_cs_n,
  input  logic                 i_mosi,
  output logic                 o_miso,
  output logic                 o_miso_oe,
  input  logic [WORD_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic [WORD_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_tx_underrun,
  output logic                 o_busy
);

  spi_state_t state, state_next;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_stages;
  logic mosi_bit;

  logic [WORD_BITS-1:0] hold_data;
  logic                 hold_full;
  logic [WORD_BITS-1:0] tx_shift;
  logic                 skip_shift;
  logic [WORD_BITS-2:0] rx_shift;
  logic [CNT_BITS-1:0]  bit_cnt;

  logic load, boundary_load, tx_accept, word_done;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk      (i_clk),
    .rst      (i_rst),
    .async_in (i_sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk      (i_clk),
    .rst      (i_rst),
    .async_in (i_cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // MOSI shares the SCLK pipeline depth so the sampled bit lines up with sclk_rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) mosi_stages <= '0;
    else       mosi_stages <= {mosi_stages[SYNC_STAGES-2:0], i_mosi};
  end
  assign mosi_bit = mosi_stages[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  assign word_done = sclk_rise && (bit_cnt == CNT_BITS'(WORD_BITS - 1));

  always_comb begin
    state_next    = state;
    load          = 1'b0;
    boundary_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_SELECTED;
          load       = 1'b1;
        end
      end
      ST_SELECTED: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else if (word_done) begin
          load          = 1'b1;
          boundary_load = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign tx_accept = i_tx_valid && !hold_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_data     <= '0;
      hold_full     <= 1'b0;
      tx_shift      <= '0;
      skip_shift    <= 1'b0;
      rx_shift      <= '0;
      bit_cnt       <= '0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;

      // A write landing with a load refills the register after the load drains it.
      hold_full <= (hold_full && !load) || tx_accept;
      if (tx_accept) hold_data <= i_tx_data;

      if (load) begin
        tx_shift      <= hold_full ? hold_data : UNDERRUN_FILL;
        o_tx_underrun <= !hold_full;
        skip_shift    <= boundary_load;
      end else if (state == ST_SELECTED && sclk_fall) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            tx_shift   <= {tx_shift[WORD_BITS-2:0], 1'b0};
      end

      if (state == ST_SELECTED) begin
        if (cs_rise) begin
          bit_cnt  <= '0;
          rx_shift <= '0;
        end else if (sclk_rise) begin
          rx_shift <= {rx_shift[WORD_BITS-3:0], mosi_bit};
          bit_cnt  <= bit_cnt + 1'b1;
          if (word_done) begin
            o_rx_data  <= {rx_shift, mosi_bit};
            o_rx_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign o_busy     = (state == ST_SELECTED);
  assign o_miso_oe  = o_busy;
  assign o_miso     = o_busy & tx_shift[WORD_BITS-1];
  assign o_tx_ready = !hold_full;

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: scoreboard bench driving the peripheral as an SPI mode-0 controller.
// Rev 1.0
`default_nettype none

module tb_spi_peripheral;

  localparam int SYNC     = 2;
  localparam int MIN_HALF = SYNC + 1;
  localparam int SLOW     = 6;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] rx_data;

  spi_peripheral #(.SYNC_STAGES(SYNC)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sclk        (sclk),
    .i_cs_n        (cs_n),
    .i_mosi        (mosi),
    .o_miso        (miso),
    .o_miso_oe     (miso_oe),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_tx_underrun (tx_underrun),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_rise_cyc = 0;

  // Reference model: holding register as a queue, expected responses as queues.
  logic [7:0] model_hold[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] cur_tx;
  int         exp_underruns = 0;
  int         obs_underruns = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_load();
    if (model_hold.size() != 0) begin
      cur_tx = model_hold.pop_front();
    end else begin
      cur_tx = 8'h00;
      exp_underruns++;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge sclk) last_rise_cyc = cyc;

  // Receive-side and underrun monitor.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: got byte %02h expected no byte", rx_data);
      end else begin
        check("rx_data", rx_data, exp_rx_q.pop_front());
        check("rx_latency", cyc - last_rise_cyc, SYNC + 1);
      end
    end
    if (tx_underrun) obs_underruns++;
  end

  // MISO monitor: what a mode-0 controller captures on each SCLK rise.
  int         miso_cnt = 0;
  logic [7:0] miso_acc = 8'h00;
  always @(posedge sclk) begin
    if (!cs_n) begin
      check("miso_oe", miso_oe, 1);
      miso_acc = {miso_acc[6:0], miso};
      miso_cnt++;
      if (miso_cnt == 8) begin
        miso_cnt = 0;
        if (exp_tx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL miso_unexpected: got byte %02h expected no byte", miso_acc);
        end else begin
          check("miso_byte", miso_acc, exp_tx_q.pop_front());
        end
      end
    end
  end
  always @(posedge cs_n) miso_cnt = 0;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] d);
    check("tx_ready_before_write", tx_ready, model_hold.size() == 0);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clks(1);
    tx_valid = 1'b0;
    model_hold.push_back(d);
  endtask

  task automatic cs_select();
    cs_n = 1'b0;
    model_load();
    wait_clks(8);
  endtask

  task automatic cs_deselect(input int half);
    wait_clks(half);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic spi_byte(input logic [7:0] m, input int nbits, input bit do_write,
                          input logic [7:0] wd, input int half);
    if (nbits == 8) begin
      exp_tx_q.push_back(cur_tx);
      exp_rx_q.push_back(m);
    end
    for (int k = 0; k < nbits; k++) begin
      mosi = m[7-k];
      wait_clks(half);
      sclk = 1'b1;
      if (k == 7) model_load();
      if (do_write && k == 3) begin
        tx_write(wd);
        wait_clks(half - 1);
      end else begin
        wait_clks(half);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_miso_oe"}, miso_oe, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_rx_data"}, rx_data, 8'h00);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_tx_underrun"}, tx_underrun, 0);
  endtask

  initial begin
    #2_000_000;
    tests++;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    rst      = 1'b1;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    cur_tx   = 8'h00;
    wait_clks(4);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(4);

    // Preloaded byte out, 0x3C in.
    tx_write(8'hA5);
    check("tx_ready_full", tx_ready, 0);
    cs_select();
    check("busy_selected", busy, 1);
    check("tx_ready_after_load", tx_ready, 1);
    spi_byte(8'h3C, 8, 1'b0, 8'h00, SLOW);
    cs_deselect(SLOW);
    check("busy_idle", busy, 0);
    check("rx_hold_3c", rx_data, 8'h3C);

    // Empty holding register: zeros on MISO with underrun.
    cs_select();
    spi_byte(8'h96, 8, 1'b0, 8'h00, SLOW);
    cs_deselect(SLOW);

    // Back-to-back words, second written during the first.
    tx_write(8'h11);
    cs_select();
    spi_byte(8'h5A, 8, 1'b1, 8'h22, SLOW);
    spi_byte(8'hC3, 8, 1'b0, 8'h00, SLOW);
    cs_deselect(SLOW);

    // Partial word discarded, then a full one.
    cs_select();
    spi_byte(8'hFF, 5, 1'b0, 8'h00, SLOW);
    cs_deselect(SLOW);
    cs_select();
    spi_byte(8'hF0, 8, 1'b0, 8'h00, SLOW);
    cs_deselect(SLOW);
    check("rx_hold_f0", rx_data, 8'hF0);

    // Reset mid-transfer.
    cs_select();
    spi_byte(8'hAA, 4, 1'b0, 8'h00, SLOW);
    tx_write(8'h5A);
    wait_clks(2);
    rst  = 1'b1;
    cs_n = 1'b1;
    wait_clks(1);
    check_reset_outputs("midreset");
    wait_clks(2);
    rst = 1'b0;
    model_hold.delete();
    for (int k = 0; k < 16; k++) begin
      mosi = k[0];
      wait_clks(SLOW);
      sclk = 1'b1;
      wait_clks(SLOW);
      sclk = 1'b0;
    end
    wait_clks(10);
    check("busy_after_reset", busy, 0);

    // Random traffic at the minimum SCLK phase width.
    for (int f = 0; f < 4; f++) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      cs_select();
      for (int b = 0; b < 16; b++) begin
        spi_byte(8'($urandom), 8, bit'($urandom_range(0, 1)), 8'($urandom), MIN_HALF);
      end
      cs_deselect(MIN_HALF);
    end

    wait_clks(20);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("miso_queue_drained", exp_tx_q.size(), 0);
    check("underrun_count", obs_underruns, exp_underruns);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
